// File: rtl/serial_rx_if.sv
// Word handoff between the serial receiver and its consumer.
// The receiver is the master; it holds data_out until data_ready takes it.
interface serial_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serial_rx.sv
// Serial frame receiver: start detect, mid-bit sampling, LSB-first shift,
// stop check, and a single-word valid/ready holding register.
module serial_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx_in,
    serial_rx_if.master rx_if,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST    = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic [DATA_BITS-1:0] shifted;
    logic                 good;
    logic                 accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        good    = 1'b0;
        accept  = valid_q & rx_if.data_ready;
        // New bits enter at the MSB so the first bit ends up in bit 0.
        shifted = shift_q >> 1;
        shifted[DATA_BITS-1] = rx_in;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_in) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_in) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = shifted;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_in) begin
                        good = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A held word that is not being taken blocks the new one.
        if (good) begin
            if (valid_q && !rx_if.data_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_valid = valid_q;
    assign frame_err        = ferr_q;
    assign overrun          = ovr_q;
endmodule

// File: doc/serial_rx.md
# serial_rx

Serial frame receiver that consumes the synchronized serial bit produced by the upstream D flip-flop synchronizer stage. It performs start-bit detection, mid-bit sampling, LSB-first deserialization and stop-bit checking, then presents each received word through a valid/ready holding register to downstream logic. It also reports framing errors and overruns.

## Interface

Parameters:
- DATA_BITS, 8, data bits per frame (1–16).
- CLKS_PER_BIT, 16, clk cycles per serial bit. Must be even and ≥ 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high. Forces every register to its reset value immediately.
- rx_in  input  1  synchronized serial line from the flip-flop stage. Idle level is 1.
- data_ready  input  1  downstream accepts data_out on a rising edge while data_valid=1.
- data_out  output  DATA_BITS  last good received word. Reset value 0.
- data_valid  output  1  data_out holds an unaccepted word. Reset value 0.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0. Reset value 0.
- overrun  output  1  one-cycle pulse when a good frame is dropped. Reset value 0.

## Operation

- The FSM has four states: IDLE, START, DATA and STOP. The reset state is IDLE.
- The bit-timing counter is $clog2(CLKS_PER_BIT) bits wide. The bit index is $clog2(DATA_BITS+1) bits wide. The shift register is DATA_BITS wide. All of these reset to 0.
- IDLE: on an edge where rx_in=0, go to START and clear the counter.
- START: after CLKS_PER_BIT/2 cycles, sample rx_in.
  - If rx_in=0, go to DATA, clear the counter and set the bit index to 0.
  - If rx_in=1, this is a false start. Return to IDLE with no output activity.
- DATA: every CLKS_PER_BIT cycles, sample rx_in into bit[index], LSB first.
  - After bit DATA_BITS-1 is sampled, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_in and return to IDLE on that same edge.
  - If rx_in=1 (good frame): load data_out from the shift register and set data_valid=1.
  - If rx_in=0: pulse frame_err for one cycle. data_out and data_valid are untouched.
- Handshake: on an edge with data_valid=1 and data_ready=1, the word is consumed and data_valid clears.
  - data_ready while data_valid=0 has no effect.
- Overrun: a good frame completes while data_valid=1 and data_ready=0.
  - The new word is discarded.
  - data_out keeps the old word and data_valid stays 1.
  - overrun pulses for one cycle.
- Simultaneous accept and completion: the old word is consumed and the new word loads on the same edge. data_valid stays 1 and there is no overrun.
- rx_in is ignored except at sample points and while in IDLE. Glitches between sample points have no effect.
- clr asserted mid-frame aborts the frame with no error pulse. After release, the block waits in IDLE for a fresh falling edge.

## Timing

- Let E0 be the edge on which IDLE sees rx_in=0.
- Start sample is at E0 + CLKS_PER_BIT/2.
- Data bit k (k = 0..DATA_BITS-1) is sampled at E0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop sample is at E0 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT. With defaults this is E0+152.
- data_valid, frame_err and overrun update on the stop-sample edge, so they are visible in the cycle after it.
- The FSM is in IDLE on the cycle after the stop sample. A start bit beginning on that edge is detected. Back-to-back frames need no idle gap.
- Acceptance latency: data_valid falls on the same edge that samples data_ready=1.
- No combinational path from any input to any output. All outputs are registered.

## Test plan

- Default parameters; send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1), data_ready=0 -> data_out=0xA5, data_valid=1 from E0+153 onward; frame_err=0, overrun=0.
- rx_in low for 4 cycles, then high -> START aborts at E0+8, FSM returns to IDLE; data_valid, frame_err and overrun all stay 0.
- Frame 0x3C with stop bit 0 -> frame_err high for exactly one cycle after E0+152; data_valid=0; data_out=0.
- Two back-to-back frames 0x3C then 0xC3, data_ready=0 -> data_out=0x3C and data_valid=1 throughout; overrun pulses one cycle after the second stop sample. Then data_ready=1 for one edge -> data_valid=0.
- Two back-to-back frames 0x11 and 0x22 with data_ready pulsed exactly on the second stop-sample edge -> data_out=0x22, data_valid=1, overrun=0.
- clr asserted asynchronously during DATA bit 3 of 0xFF -> all outputs 0 immediately. After release, frame 0x5A is received -> data_out=0x5A, data_valid=1, no error pulses.
